// File: rtl/ped_xing_ctrl.sv
// Pedestrian-crossing controller: merges N_REQ debounced request buttons,
// sequences WAIT -> CROSS -> (FLASH) -> RELAX on a tick-driven down-counter
// and drives the traffic/wait/walk lamps.
module ped_xing_ctrl #(
   parameter int N_REQ    = 2,
   parameter int CNT_W    = 8,
   parameter int WAIT_T   = 4,
   parameter int CROSS_T  = 8,
   parameter int FLASH_T  = 4,
   parameter int RELAX_T  = 6,
   parameter int EN_FLASH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             hold,
   input  logic [N_REQ-1:0] button,
   output logic [2:0]       led,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remain,
   output logic             served,
   output logic [N_REQ-1:0] served_mask
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] CROSS = 3'd2;
   localparam logic [2:0] FLASH = 3'd3;
   localparam logic [2:0] RELAX = 3'd4;

   localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_T);
   localparam logic [CNT_W-1:0] CROSS_L = CNT_W'(CROSS_T);
   localparam logic [CNT_W-1:0] FLASH_L = CNT_W'(FLASH_T);
   localparam logic [CNT_W-1:0] RELAX_L = CNT_W'(RELAX_T);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             blink_q, blink_d;
   logic [N_REQ-1:0] btn_q;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] mask_q, mask_d;
   logic             served_q;
   logic [N_REQ-1:0] btn_edge;
   logic             cross_entry;
   logic             adv;
   logic             last;

   // Next-state: phase sequencing, counter load/decrement, request latching
   always_comb begin
      btn_edge    = button & ~btn_q;
      adv         = tick & ~hold;
      last        = (remain_q == ONE);
      phase_d     = phase_q;
      remain_d    = remain_q;
      blink_d     = blink_q;
      cross_entry = 1'b0;
      case (phase_q)
         IDLE: begin
            if (!hold && (|pending_q)) begin
               phase_d  = WAIT;
               remain_d = WAIT_L;
            end
         end
         WAIT: begin
            if (adv) begin
               if (last) begin
                  phase_d     = CROSS;
                  remain_d    = CROSS_L;
                  cross_entry = 1'b1;
               end else begin
                  remain_d = remain_q - ONE;
               end
            end
         end
         CROSS: begin
            if (adv) begin
               if (last) begin
                  if (EN_FLASH != 0) begin
                     phase_d  = FLASH;
                     remain_d = FLASH_L;
                     blink_d  = 1'b1;
                  end else begin
                     phase_d  = RELAX;
                     remain_d = RELAX_L;
                  end
               end else begin
                  remain_d = remain_q - ONE;
               end
            end
         end
         FLASH: begin
            if (adv) begin
               blink_d = ~blink_q;
               if (last) begin
                  phase_d  = RELAX;
                  remain_d = RELAX_L;
               end else begin
                  remain_d = remain_q - ONE;
               end
            end
         end
         RELAX: begin
            if (adv) begin
               if (last) begin
                  phase_d  = IDLE;
                  remain_d = '0;
               end else begin
                  remain_d = remain_q - ONE;
               end
            end
         end
         default: begin
            phase_d  = IDLE;
            remain_d = '0;
         end
      endcase
      // An edge arriving in the CROSS-entry cycle is kept for the next round
      pending_d = (pending_q & ~{N_REQ{cross_entry}}) | btn_edge;
      mask_d    = cross_entry ? (pending_q | btn_edge) : mask_q;
   end

   // State registers with synchronous reset; btn_q tracks button even in reset
   always_ff @(posedge clk) begin
      btn_q <= button;
      if (reset) begin
         phase_q   <= IDLE;
         remain_q  <= '0;
         blink_q   <= 1'b0;
         pending_q <= '0;
         mask_q    <= '0;
         served_q  <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         remain_q  <= remain_d;
         blink_q   <= blink_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         served_q  <= cross_entry;
      end
   end

   // Lamp decode from the registered phase
   always_comb begin
      case (phase_q)
         WAIT:    led = 3'b010;
         CROSS:   led = 3'b100;
         FLASH:   led = {blink_q, 2'b00};
         default: led = 3'b001;
      endcase
   end

   assign phase       = phase_q;
   assign remain      = remain_q;
   assign served      = served_q;
   assign served_mask = mask_q;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Directed bench for ped_xing_ctrl: default instance with tick every cycle,
// plus an EN_FLASH=0 instance ticked every third cycle.
module tb_ped_xing_ctrl;

   logic       clk = 1'b0;
   logic       reset, tick, hold;
   logic [1:0] button;
   logic [2:0] led, phase;
   logic [7:0] remain;
   logic       served;
   logic [1:0] served_mask;

   logic       reset2, tick2, hold2;
   logic [1:0] button2;
   logic [2:0] led2, phase2;
   logic [7:0] remain2;
   logic       served2;
   logic [1:0] served_mask2;

   int n_assert = 0;
   int n_fail   = 0;
   logic found;

   always #5 clk = ~clk;

   ped_xing_ctrl dut (
      .clk(clk), .reset(reset), .tick(tick), .hold(hold), .button(button),
      .led(led), .phase(phase), .remain(remain), .served(served),
      .served_mask(served_mask)
   );

   ped_xing_ctrl #(.EN_FLASH(0)) dut2 (
      .clk(clk), .reset(reset2), .tick(tick2), .hold(hold2), .button(button2),
      .led(led2), .phase(phase2), .remain(remain2), .served(served2),
      .served_mask(served_mask2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Tick for the second instance: high every third cycle
   initial begin
      tick2 = 1'b0;
      forever begin
         repeat (2) @(negedge clk);
         tick2 = 1'b1;
         @(negedge clk);
         tick2 = 1'b0;
      end
   end

   initial begin
      reset = 1'b1; tick = 1'b1; hold = 1'b0; button = 2'b00;
      reset2 = 1'b1; hold2 = 1'b0; button2 = 2'b00;

      // Reset state
      cyc(2);
      chk("rst_phase", phase, 0);
      chk("rst_remain", remain, 0);
      chk("rst_led", led, 3'b001);
      chk("rst_served", served, 0);
      chk("rst_mask", served_mask, 0);
      reset = 1'b0;

      // Test 1: full sequence from button[0]
      cyc(1);
      button = 2'b01;
      cyc(1);
      chk("t1_idle_e1", phase, 0);
      cyc(1);
      chk("t1_wait_phase", phase, 1);
      chk("t1_wait_led", led, 3'b010);
      chk("t1_wait_remain", remain, 4);
      button = 2'b00;
      cyc(3);
      chk("t1_wait_last", remain, 1);
      chk("t1_wait_still", phase, 1);
      cyc(1);
      chk("t1_cross_phase", phase, 2);
      chk("t1_served", served, 1);
      chk("t1_mask", served_mask, 2'b01);
      chk("t1_cross_remain", remain, 8);
      chk("t1_cross_led", led, 3'b100);
      cyc(1);
      chk("t1_served_pulse", served, 0);
      chk("t1_cross_dec", remain, 7);
      cyc(7);
      chk("t1_flash_phase", phase, 3);
      chk("t1_flash_led_on", led, 3'b100);
      chk("t1_flash_remain", remain, 4);
      cyc(1);
      chk("t1_flash_led_off", led, 3'b000);
      cyc(3);
      chk("t1_relax_phase", phase, 4);
      chk("t1_relax_led", led, 3'b001);
      chk("t1_relax_remain", remain, 6);
      cyc(6);
      chk("t1_idle_phase", phase, 0);
      chk("t1_idle_remain", remain, 0);

      // Test 2: request during CROSS served in the next round
      button = 2'b01;
      cyc(2);
      chk("t2_wait", phase, 1);
      button = 2'b00;
      cyc(4);
      chk("t2_cross", phase, 2);
      cyc(2);
      button = 2'b10;
      cyc(1);
      chk("t2_mask_kept", served_mask, 2'b01);
      chk("t2_still_cross", phase, 2);
      button = 2'b00;
      cyc(5);
      chk("t2_flash", phase, 3);
      cyc(4);
      chk("t2_relax", phase, 4);
      cyc(6);
      chk("t2_idle_visit", phase, 0);
      cyc(1);
      chk("t2_rewait", phase, 1);
      cyc(4);
      chk("t2_recross", phase, 2);
      chk("t2_reserved", served, 1);
      chk("t2_remask", served_mask, 2'b10);
      cyc(18);
      chk("t2_end_idle", phase, 0);
      cyc(1);
      chk("t2_stay_idle", phase, 0);
      chk("t2_mask_held", served_mask, 2'b10);

      // Test 3: button held through reset yields no request
      button = 2'b01;
      reset  = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("t3_rst_mask", served_mask, 0);
      cyc(5);
      chk("t3_no_wait", phase, 0);
      chk("t3_no_remain", remain, 0);
      button = 2'b00;
      cyc(1);
      button = 2'b01;
      cyc(1);
      chk("t3_idle_e1", phase, 0);
      cyc(1);
      chk("t3_wait", phase, 1);
      button = 2'b00;

      // Test 4: hold freezes CROSS for 5 cycles; requests still latch
      cyc(4);
      chk("t4_cross", phase, 2);
      cyc(2);
      chk("t4_pre_hold", remain, 6);
      hold = 1'b1;
      cyc(1);
      button = 2'b10;
      cyc(1);
      button = 2'b00;
      cyc(3);
      chk("t4_hold_remain", remain, 6);
      chk("t4_hold_phase", phase, 2);
      chk("t4_hold_led", led, 3'b100);
      hold = 1'b0;
      cyc(1);
      chk("t4_resume", remain, 5);
      cyc(4);
      chk("t4_last", remain, 1);
      chk("t4_still_cross", phase, 2);
      cyc(1);
      chk("t4_flash", phase, 3);

      // Test 6: reset mid-FLASH aborts and discards the latched request
      cyc(1);
      chk("t6_flash_led", led, 3'b000);
      reset = 1'b1;
      cyc(1);
      chk("t6_led", led, 3'b001);
      chk("t6_phase", phase, 0);
      chk("t6_remain", remain, 0);
      chk("t6_mask", served_mask, 0);
      chk("t6_served", served, 0);
      reset = 1'b0;
      cyc(4);
      chk("t6_no_request", phase, 0);

      // Test 5: EN_FLASH=0, tick every third cycle
      reset2 = 1'b0;
      cyc(1);
      button2 = 2'b01;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (phase2 == 3'd2) found = 1'b1;
      end
      chk("t5_cross_reached", found, 1);
      button2 = 2'b00;
      chk("t5_served", served2, 1);
      chk("t5_remain", remain2, 8);
      chk("t5_led", led2, 3'b100);
      cyc(3);
      chk("t5_dec", remain2, 7);
      cyc(20);
      chk("t5_cross_end", phase2, 2);
      chk("t5_cross_last", remain2, 1);
      cyc(1);
      chk("t5_relax", phase2, 4);
      chk("t5_relax_led", led2, 3'b001);
      chk("t5_relax_remain", remain2, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
